// File: rtl/esc_sint_conditioner.sv
// esc_sint_conditioner
//   Conditions the active-low SINT interrupt pin from the EtherCAT slave
//   controller before it reaches the PIO edge-capture input. The pin is
//   synchronised, glitch-filtered, and stretched to a minimum low time, so
//   each accepted event shows up as exactly one clean falling edge.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | output high, waiting for a filtered low level
//   ASSERT | output low, minimum-low stretch timer running
//   HOLD   | stretch expired, output held low until the filtered level rises
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   sint_n_in    raw asynchronous SINT pin (active-low)
//   clr_count    synchronous clear of event_count
//   sint_n_out   conditioned SINT (active-low), feeds the PIO in_port
//   fall_pulse   one-cycle strobe per accepted event
//   stuck_low    accepted-low level has lasted STUCK_CYCLES or longer
//   event_count  saturating count of accepted events
module esc_sint_conditioner #(
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int STUCK_CYCLES   = 50000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sint_n_in,
  input  logic                 clr_count,
  output logic                 sint_n_out,
  output logic                 fall_pulse,
  output logic                 stuck_low,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [7:0]    FILT_LAST    = 8'(FILTER_CYCLES - 1);
  localparam logic [7:0]    STRETCH_LOAD = 8'(STRETCH_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_MAX    = SW'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  logic                 s1_q, s2_q;
  logic                 filt_q;
  logic [7:0]           fcnt_q;
  state_t               state_q;
  logic [7:0]           stretch_q;
  logic [SW-1:0]        stuck_cnt_q;
  logic                 sint_n_q;
  logic                 fall_q;
  logic                 stuck_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 event_d;

  // Synchroniser and glitch filter: filt_q follows s2_q only after s2_q has
  // differed from it for FILTER_CYCLES consecutive edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      s1_q <= sint_n_in;
      s2_q <= s1_q;
      if (s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FILT_LAST) begin
        filt_q <= s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign event_d = (state_q == IDLE) && !filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stretch_q   <= '0;
      stuck_cnt_q <= '0;
      sint_n_q    <= 1'b1;
      fall_q      <= 1'b0;
      stuck_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      fall_q <= 1'b0;

      // Stuck timer runs only while an event is active and the line is low;
      // an IDLE entry below overrides the flag.
      if (state_q != IDLE && !filt_q && stuck_cnt_q != STUCK_MAX) begin
        stuck_cnt_q <= stuck_cnt_q + 1'b1;
        if (stuck_cnt_q + 1'b1 == STUCK_MAX) stuck_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          stuck_cnt_q <= '0;
          if (!filt_q) begin
            state_q   <= ASSERT;
            stretch_q <= STRETCH_LOAD;
            fall_q    <= 1'b1;
            sint_n_q  <= 1'b0;
          end
        end
        ASSERT: begin
          // A filt bounce inside the stretch window is absorbed: no reload.
          if (stretch_q != 8'd0) begin
            stretch_q <= stretch_q - 8'd1;
          end else if (filt_q) begin
            state_q  <= IDLE;
            sint_n_q <= 1'b1;
            stuck_q  <= 1'b0;
          end else begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (filt_q) begin
            state_q  <= IDLE;
            sint_n_q <= 1'b1;
            stuck_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          sint_n_q <= 1'b1;
          stuck_q  <= 1'b0;
        end
      endcase

      // Clear takes effect first, so a coincident event leaves a count of 1.
      if (clr_count) begin
        count_q <= event_d ? CNT_WIDTH'(1) : '0;
      end else if (event_d && count_q != {CNT_WIDTH{1'b1}}) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign sint_n_out  = sint_n_q;
  assign fall_pulse  = fall_q;
  assign stuck_low   = stuck_q;
  assign event_count = count_q;

endmodule

// File: tb/tb_esc_sint_conditioner.sv
module tb_esc_sint_conditioner;

  logic clk;
  logic reset;

  // Instance a: defaults
  logic        pin_a, clr_a, sint_a, fall_a, stuck_a;
  logic [15:0] cnt_a;
  // Instance b: short stuck timeout
  logic        pin_b, clr_b, sint_b, fall_b, stuck_b;
  logic [15:0] cnt_b;
  // Instance c: 4-bit event counter
  logic        pin_c, clr_c, sint_c, fall_c, stuck_c;
  logic [3:0]  cnt_c;

  int n_chk;
  int n_pass;

  esc_sint_conditioner u_dut_a (
    .clk(clk), .reset(reset), .sint_n_in(pin_a), .clr_count(clr_a),
    .sint_n_out(sint_a), .fall_pulse(fall_a), .stuck_low(stuck_a),
    .event_count(cnt_a)
  );

  esc_sint_conditioner #(.STUCK_CYCLES(100)) u_dut_b (
    .clk(clk), .reset(reset), .sint_n_in(pin_b), .clr_count(clr_b),
    .sint_n_out(sint_b), .fall_pulse(fall_b), .stuck_low(stuck_b),
    .event_count(cnt_b)
  );

  esc_sint_conditioner #(.CNT_WIDTH(4)) u_dut_c (
    .clk(clk), .reset(reset), .sint_n_in(pin_c), .clr_count(clr_c),
    .sint_n_out(sint_c), .fall_pulse(fall_c), .stuck_low(stuck_c),
    .event_count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Edge e of the window is the e-th posedge after the call; the pin value
  // in effect at edge e is low when e falls inside either low range.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int lo1_s, input int lo1_e, input int lo2_s, input int lo2_e,
                       input int win, output int lows, output int falls,
                       output int first_low, output int first_fall);
    lows = 0; falls = 0; first_low = 0; first_fall = 0;
    for (int e = 1; e <= win; e++) begin
      pin_a = ((e >= lo1_s && e <= lo1_e) || (e >= lo2_s && e <= lo2_e)) ? 1'b0 : 1'b1;
      tick();
      if (!sint_a) begin
        lows++;
        if (first_low == 0) first_low = e;
      end
      if (fall_a) begin
        falls++;
        if (first_fall == 0) first_fall = e;
      end
    end
    pin_a = 1'b1;
  endtask

  int lows, falls, fl, ff;

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1;
    pin_a = 1'b1; pin_b = 1'b1; pin_c = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    #1;
    chk("rst_sint", {31'd0, sint_a}, 32'd1);
    chk("rst_fall", {31'd0, fall_a}, 32'd0);
    chk("rst_stuck", {31'd0, stuck_b}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();

    // 40-cycle low: out low from edge 7 to edge 46, pulse at edge 7
    run_a(1, 40, 0, -1, 55, lows, falls, fl, ff);
    chk("t1_first_low", fl, 7);
    chk("t1_low_len", lows, 40);
    chk("t1_first_fall", ff, 7);
    chk("t1_falls", falls, 1);
    chk("t1_cnt", {16'd0, cnt_a}, 32'd1);

    // 3 low, 2 high, 3 low: rejected
    run_a(1, 3, 6, 8, 25, lows, falls, fl, ff);
    chk("t2_lows", lows, 0);
    chk("t2_falls", falls, 0);
    chk("t2_cnt", {16'd0, cnt_a}, 32'd1);

    // 4-cycle pulse: accepted, stretched to exactly 8
    run_a(1, 4, 0, -1, 25, lows, falls, fl, ff);
    chk("t3_first_low", fl, 7);
    chk("t3_low_len", lows, 8);
    chk("t3_falls", falls, 1);
    chk("t3_cnt", {16'd0, cnt_a}, 32'd2);

    clr_a = 1'b1; tick(); clr_a = 1'b0;
    chk("clr_cnt", {16'd0, cnt_a}, 32'd0);
    repeat (3) tick();

    // Re-assertion inside the stretch: one merged 13-cycle low
    run_a(1, 4, 9, 13, 30, lows, falls, fl, ff);
    chk("t4_first_low", fl, 7);
    chk("t4_low_len", lows, 13);
    chk("t4_falls", falls, 1);
    chk("t4_cnt", {16'd0, cnt_a}, 32'd1);
    run_a(1, 4, 0, -1, 25, lows, falls, fl, ff);
    chk("t4b_low_len", lows, 8);
    chk("t4b_cnt", {16'd0, cnt_a}, 32'd2);

    // Stuck timer on instance b: pin low edges 1..150
    for (int e = 1; e <= 160; e++) begin
      pin_b = (e <= 150) ? 1'b0 : 1'b1;
      tick();
      if (e == 106) chk("stk_pre", {31'd0, stuck_b}, 32'd0);
      if (e == 107) chk("stk_set", {31'd0, stuck_b}, 32'd1);
      if (e == 156) chk("stk_hold", {30'd0, stuck_b, sint_b}, 32'd2);
      if (e == 157) chk("stk_clr", {30'd0, stuck_b, sint_b}, 32'd1);
    end
    chk("stk_cnt", {16'd0, cnt_b}, 32'd1);

    // Saturation on instance c
    for (int p = 0; p < 17; p++) begin
      pin_c = 1'b0; repeat (4) tick();
      pin_c = 1'b1; repeat (20) tick();
    end
    chk("sat_cnt", {28'd0, cnt_c}, 32'd15);

    // Clear coincident with an accepted event
    for (int e = 1; e <= 8; e++) begin
      pin_c = (e <= 4) ? 1'b0 : 1'b1;
      clr_c = (e == 7) ? 1'b1 : 1'b0;
      tick();
      if (e == 7) chk("clr_evt_cnt", {28'd0, cnt_c}, 32'd1);
    end
    clr_c = 1'b0;
    chk("mid_assert_sint", {31'd0, sint_c}, 32'd0);

    // Asynchronous reset while ASSERT, pin held low
    pin_c = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_sint", {31'd0, sint_c}, 32'd1);
    chk("arst_fall", {31'd0, fall_c}, 32'd0);
    chk("arst_cnt", {28'd0, cnt_c}, 32'd0);
    tick();
    #2 reset = 1'b0;
    // Still-low pin re-sampled from idle-high: new event at edge 7
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) chk("rel_pre", {31'd0, sint_c}, 32'd1);
      if (e == 7) chk("rel_evt", {30'd0, sint_c, fall_c}, 32'd1);
    end
    chk("rel_cnt", {28'd0, cnt_c}, 32'd1);
    pin_c = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
